// File: rtl/nn_select_pkg.sv
// Shared types and helpers for the streaming argmax selector.
// The score width here must match DATA_W of argmax_stream_select.
package nn_select_pkg;

  localparam int SCORE_W = 16;

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_e;

  typedef logic signed [SCORE_W-1:0] score_t;

  localparam score_t SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  // Unsigned distance between best and runner-up; clamps to zero if inverted.
  function automatic logic [SCORE_W-1:0] sat_sub_margin(input score_t best, input score_t second);
    logic signed [SCORE_W:0] diff;
    diff = $signed({best[SCORE_W-1], best}) - $signed({second[SCORE_W-1], second});
    if (diff[SCORE_W]) begin
      sat_sub_margin = {SCORE_W{1'b0}};
    end else begin
      sat_sub_margin = diff[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/argmax_cmp_update.sv
// Combinational compare/update of the running {max, index, second} from one score beat.
// MARGIN_EN adds the runner-up score path.
module argmax_cmp_update
  import nn_select_pkg::*;
#(
  parameter int DATA_W = SCORE_W,
  parameter int IDX_W  = 4
) (
  input  logic                     first,
  input  logic signed [DATA_W-1:0] beat_data,
  input  logic [IDX_W-1:0]         beat_idx,
  input  logic signed [DATA_W-1:0] cur_max,
  input  logic [IDX_W-1:0]         cur_idx,
`ifdef MARGIN_EN
  input  logic signed [DATA_W-1:0] cur_second,
  output logic signed [DATA_W-1:0] nxt_second,
`endif
  output logic signed [DATA_W-1:0] nxt_max,
  output logic [IDX_W-1:0]         nxt_idx
);

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    nxt_max = cur_max;
    nxt_idx = cur_idx;
`ifdef MARGIN_EN
    nxt_second = cur_second;
`endif
    if (first) begin
      nxt_max = beat_data;
      nxt_idx = beat_idx;
`ifdef MARGIN_EN
      nxt_second = SCORE_MIN;
`endif
    end else if (beat_data > cur_max) begin
      nxt_max = beat_data;
      nxt_idx = beat_idx;
`ifdef MARGIN_EN
      nxt_second = cur_max;
`endif
    end else begin
`ifdef MARGIN_EN
      if (beat_data > cur_second) begin
        nxt_second = beat_data;
      end else begin
        nxt_second = cur_second;
      end
`endif
    end
  end

endmodule

// File: rtl/argmax_stream_select.sv
// Streaming argmax over one frame of NEURON_NB signed scores, result over valid/ready.
// Optional MARGIN_EN macro adds best-minus-second confidence margin output.
module argmax_stream_select
  import nn_select_pkg::*;
#(
  parameter int NEURON_NB = 10,
  parameter int DATA_W    = SCORE_W,
  parameter int IDX_W     = $clog2(NEURON_NB)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [IDX_W-1:0]         res_index,
  output logic signed [DATA_W-1:0] res_max,
  output logic                     res_len_err
`ifdef MARGIN_EN
  ,
  output logic [DATA_W-1:0]        res_margin
`endif
);

  localparam int CNT_W = $clog2(NEURON_NB + 1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic signed [DATA_W-1:0]   max_q, max_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       in_ready_q, in_ready_d;
  logic                       res_valid_q, res_valid_d;
  logic [IDX_W-1:0]           res_index_q, res_index_d;
  logic signed [DATA_W-1:0]   res_max_q, res_max_d;
  logic                       res_len_err_q, res_len_err_d;

  logic signed [DATA_W-1:0]   cmp_max_s;
  logic [IDX_W-1:0]           cmp_idx_s;
  logic                       accept_s;
  logic                       first_s;
  logic                       eof_s;

`ifdef MARGIN_EN
  logic signed [DATA_W-1:0]   second_q, second_d;
  logic [DATA_W-1:0]          res_margin_q, res_margin_d;
  logic signed [DATA_W-1:0]   cmp_second_s;
`endif

  assign accept_s = in_valid & in_ready_q;
  assign first_s  = (count_q == {CNT_W{1'b0}});
  // The NEURON_NB-th beat closes the frame even without in_last, so count never wraps.
  assign eof_s    = in_last | (count_q == CNT_W'(NEURON_NB - 1));

  argmax_cmp_update #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .first      (first_s),
    .beat_data  (in_data),
    .beat_idx   (count_q[IDX_W-1:0]),
    .cur_max    (max_q),
    .cur_idx    (idx_q),
`ifdef MARGIN_EN
    .cur_second (second_q),
    .nxt_second (cmp_second_s),
`endif
    .nxt_max    (cmp_max_s),
    .nxt_idx    (cmp_idx_s)
  );

  // Next-state, frame accumulation and result capture.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    max_d         = max_q;
    idx_d         = idx_q;
    res_index_d   = res_index_q;
    res_max_d     = res_max_q;
    res_len_err_d = res_len_err_q;
`ifdef MARGIN_EN
    second_d      = second_q;
    res_margin_d  = res_margin_q;
`endif
    case (state_q)
      SCAN: begin
        if (accept_s) begin
          max_d = cmp_max_s;
          idx_d = cmp_idx_s;
`ifdef MARGIN_EN
          second_d = cmp_second_s;
`endif
          if (eof_s) begin
            state_d       = HOLD;
            count_d       = {CNT_W{1'b0}};
            res_index_d   = cmp_idx_s;
            res_max_d     = cmp_max_s;
            res_len_err_d = in_last ? (count_q != CNT_W'(NEURON_NB - 1)) : 1'b1;
`ifdef MARGIN_EN
            res_margin_d  = first_s ? {DATA_W{1'b1}} : sat_sub_margin(cmp_max_s, cmp_second_s);
`endif
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          state_d = SCAN;
        end
      end
      HOLD: begin
        if (res_valid_q && res_ready) begin
          state_d = SCAN;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = SCAN;
        count_d = {CNT_W{1'b0}};
      end
    endcase
    in_ready_d  = (state_d == SCAN);
    res_valid_d = (state_d == HOLD);
  end

  // State and result registers; reset discards any partial or held frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SCAN;
      count_q       <= {CNT_W{1'b0}};
      max_q         <= {DATA_W{1'b0}};
      idx_q         <= {IDX_W{1'b0}};
      in_ready_q    <= 1'b1;
      res_valid_q   <= 1'b0;
      res_index_q   <= {IDX_W{1'b0}};
      res_max_q     <= {DATA_W{1'b0}};
      res_len_err_q <= 1'b0;
`ifdef MARGIN_EN
      second_q      <= {DATA_W{1'b0}};
      res_margin_q  <= {DATA_W{1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      max_q         <= max_d;
      idx_q         <= idx_d;
      in_ready_q    <= in_ready_d;
      res_valid_q   <= res_valid_d;
      res_index_q   <= res_index_d;
      res_max_q     <= res_max_d;
      res_len_err_q <= res_len_err_d;
`ifdef MARGIN_EN
      second_q      <= second_d;
      res_margin_q  <= res_margin_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign res_valid   = res_valid_q;
  assign res_index   = res_index_q;
  assign res_max     = res_max_q;
  assign res_len_err = res_len_err_q;
`ifdef MARGIN_EN
  assign res_margin  = res_margin_q;
`endif

endmodule

// File: tb/tb_argmax_stream_select.sv
// Directed self-checking bench for argmax_stream_select: vector table plus corner sequences.
module tb_argmax_stream_select;

  localparam int NB = 10;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int NV = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_last = 1'b0;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [IW-1:0]        res_index;
  logic signed [DW-1:0] res_max;
  logic                 res_len_err;
`ifdef MARGIN_EN
  logic [DW-1:0]        res_margin;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int n;
    bit has_last;
    int e_idx;
    int e_max;
    bit e_err;
    int e_margin;
  } vec_t;

  vec_t vt [NV];
  int   sc [NV][NB];

  argmax_stream_select #(.NEURON_NB(NB), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_index   (res_index),
    .res_max     (res_max),
    .res_len_err (res_len_err)
`ifdef MARGIN_EN
    ,
    .res_margin  (res_margin)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic send_beat(input int d, input bit last);
    int g;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(d);
    in_last  = last;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) chk("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_res();
    int g;
    g = 0;
    while (!res_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!res_valid) chk("res_valid_timeout", 0, 1);
  endtask

  task automatic check_res(input string tag, input int e_idx, input int e_max,
                           input bit e_err, input int e_margin);
    chk({tag, "_index"}, longint'(res_index), e_idx);
    chk({tag, "_max"}, longint'(res_max), e_max);
    chk({tag, "_len_err"}, longint'(res_len_err), e_err);
`ifdef MARGIN_EN
    chk({tag, "_margin"}, longint'(res_margin), e_margin);
`else
    if (e_margin < 0) chk({tag, "_margin_arg"}, e_margin, 0);
`endif
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk({tag, "_hs_res_valid"}, longint'(res_valid), 0);
    chk({tag, "_hs_in_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    sc[0] = '{3, -1, 7, 2, 7, 0, 5, 1, -4, 6};
    vt[0] = '{10, 1'b1, 2, 7, 1'b0, 0};
    sc[1] = '{-5, -5, -5, -5, -5, -5, -5, -5, -2, -5};
    vt[1] = '{10, 1'b1, 8, -2, 1'b0, 3};
    sc[2] = '{1, 9, 4, 2, 0, 0, 0, 0, 0, 0};
    vt[2] = '{4, 1'b1, 1, 9, 1'b1, 5};
    sc[3] = '{-7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3] = '{1, 1'b1, 0, -7, 1'b1, 65535};
    sc[4] = '{-32768, 32767, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[4] = '{2, 1'b1, 1, 32767, 1'b1, 65535};
    sc[5] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    vt[5] = '{10, 1'b1, 0, 9, 1'b0, 1};
    sc[6] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    vt[6] = '{10, 1'b0, 9, 9, 1'b1, 1};
    sc[7] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    vt[7] = '{10, 1'b1, 0, 4, 1'b0, 0};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_res_valid", longint'(res_valid), 0);
    check_res("rst", 0, 0, 1'b0, 0);

    // Table: each frame must report res_valid on the edge after its last beat.
    for (int v = 0; v < NV; v++) begin
      for (int b = 0; b < vt[v].n; b++) begin
        send_beat(sc[v][b], vt[v].has_last && (b == vt[v].n - 1));
      end
      chk($sformatf("vec%0d_latency", v), longint'(res_valid), 1);
      check_res($sformatf("vec%0d", v), vt[v].e_idx, vt[v].e_max, vt[v].e_err, vt[v].e_margin);
      handshake($sformatf("vec%0d", v));
    end

    // Backpressure: result held 5 cycles while a stray beat is offered and must be ignored.
    for (int b = 0; b < NB; b++) send_beat((b == NB - 1) ? -3 : b + 1, b == NB - 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'sh7fff;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_res_valid", longint'(res_valid), 1);
      chk("hold_in_ready", longint'(in_ready), 0);
      check_res("hold", 8, 9, 1'b0, 1);
    end
    in_valid = 1'b0;
    handshake("hold");
    sc[0] = '{-3, -9, -1, -4, -8, -2, -7, -6, -5, -10};
    for (int b = 0; b < NB; b++) send_beat(sc[0][b], b == NB - 1);
    chk("b2b_latency", longint'(res_valid), 1);
    check_res("b2b", 2, -1, 1'b0, 1);
    handshake("b2b");

    // 12 beats without in_last: the 10th closes a frame, beats 11-12 start the next one.
    sc[1] = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};
    fork
      begin
        for (int b = 0; b < NB; b++) send_beat(sc[1][b], 1'b0);
        send_beat(7, 1'b0);
        send_beat(3, 1'b0);
      end
      begin
        wait_res();
        check_res("over_a", 9, 100, 1'b1, 10);
        repeat (2) @(negedge clk);
        chk("over_stall_in_ready", longint'(in_ready), 0);
        handshake("over_a");
      end
    join
    for (int b = 0; b < 8; b++) send_beat(1, 1'b0);
    chk("over_b_latency", longint'(res_valid), 1);
    check_res("over_b", 0, 7, 1'b1, 4);
    handshake("over_b");

    // Reset mid-frame discards the partial scores.
    sc[2] = '{100, 1, 2, 3, 4, 5, 0, 0, 0, 0};
    for (int b = 0; b < 6; b++) send_beat(sc[2][b], 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_res_valid", longint'(res_valid), 0);
    chk("midrst_in_ready", longint'(in_ready), 1);
    sc[3] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    for (int b = 0; b < NB; b++) send_beat(sc[3][b], b == NB - 1);
    chk("midrst_latency", longint'(res_valid), 1);
    check_res("midrst", 5, 9, 1'b0, 3);
    handshake("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
